fifo_serial_tx: RTL and testbench

//  Downstream drain stage for the fifo block. Pops words from the first-word-fall-through FIFO read port.

---
 rtl/fifo_serial_tx_pkg.sv | 21 ++
 rtl/fifo_serial_tx_if.sv | 34 +++
 rtl/fifo_serial_tx_baud.sv | 38 +++
 rtl/fifo_serial_tx.sv | 119 +++++++++++
 tb/tb_fifo_serial_tx.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_serial_tx_pkg.sv
// Shared types and line-level constants for the fifo serial transmitter.
package fifo_serial_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_serial_tx_if.sv
// Handshake bundle between the fifo read port, the line driver and status.
interface fifo_serial_tx_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic                  i_en;
  logic                  i_fifo_empty;
  logic [DATA_WIDTH-1:0] i_fifo_data;
  logic                  o_fifo_pop;
  logic                  o_tx;
  logic                  o_busy;
  logic                  o_frame_done;

  modport master (
    output i_en,
    output i_fifo_empty,
    output i_fifo_data,
    input  o_fifo_pop,
    input  o_tx,
    input  o_busy,
    input  o_frame_done
  );

  modport slave (
    input  i_en,
    input  i_fifo_empty,
    input  i_fifo_data,
    output o_fifo_pop,
    output o_tx,
    output o_busy,
    output o_frame_done
  );

endinterface

// File: rtl/fifo_serial_tx_baud.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while running, flags the last cycle of each bit.
module fifo_serial_tx_baud
  import fifo_serial_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic run_i,
  output logic bit_end_o
);

  localparam int unsigned   CntW   = cnt_width(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end_o = run_i && (cnt_q == CntMax);

endmodule

// File: rtl/fifo_serial_tx.sv
// Drains a first-word-fall-through fifo onto an LSB-first async serial line.
// Optional even parity bit when FIFO_SERIAL_TX_PARITY_EN is defined.
module fifo_serial_tx
  import fifo_serial_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned STOP_BITS    = 1
) (
  input logic             i_clk,
  input logic             i_rst_n,
  fifo_serial_tx_if.slave tx_if
);

  localparam int unsigned       BitW    = cnt_width(DATA_WIDTH);
  localparam logic [BitW-1:0]   BitLast = BitW'(DATA_WIDTH - 1);

  state_e                state_q;
  logic                  tx_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic [BitW-1:0]       bit_idx_q;
  logic                  stop_idx_q;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  logic                  par_q;
`endif

  logic bit_end;
  logic last_stop;
  logic frame_end;
  logic start_frame;

  assign last_stop = (STOP_BITS == 1) || stop_idx_q;
  assign frame_end = (state_q == StStop) && bit_end && last_stop;
  // Gating with reset keeps the fifo from losing a word while the line is held in reset.
  assign start_frame = i_rst_n && tx_if.i_en && !tx_if.i_fifo_empty &&
                       ((state_q == StIdle) || frame_end);
  assign shift_nxt   = shift_q >> 1;

  fifo_serial_tx_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i    (i_clk),
    .rst_ni   (i_rst_n),
    .clr_i    (start_frame),
    .run_i    (state_q != StIdle),
    .bit_end_o(bit_end)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      tx_q       <= LINE_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else if (start_frame) begin
      state_q    <= StStart;
      tx_q       <= START_BIT;
      shift_q    <= tx_if.i_fifo_data;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else if (bit_end) begin
      unique case (state_q)
        StStart: begin
          state_q <= StData;
          tx_q    <= shift_q[0];
        end
        StData: begin
          shift_q <= shift_nxt;
`ifdef FIFO_SERIAL_TX_PARITY_EN
          par_q   <= par_q ^ shift_q[0];
`endif
          if (bit_idx_q == BitLast) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
            state_q <= StParity;
            tx_q    <= par_q ^ shift_q[0];
`else
            state_q <= StStop;
            tx_q    <= STOP_BIT;
`endif
          end else begin
            bit_idx_q <= bit_idx_q + BitW'(1);
            tx_q      <= shift_nxt[0];
          end
        end
`ifdef FIFO_SERIAL_TX_PARITY_EN
        StParity: begin
          state_q <= StStop;
          tx_q    <= STOP_BIT;
        end
`endif
        StStop: begin
          if (last_stop) begin
            state_q <= StIdle;
            tx_q    <= LINE_IDLE;
          end else begin
            stop_idx_q <= 1'b1;
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  assign tx_if.o_fifo_pop   = start_frame;
  assign tx_if.o_tx         = tx_q;
  assign tx_if.o_busy       = (state_q != StIdle);
  assign tx_if.o_frame_done = frame_end;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Randomised and directed bench for fifo_serial_tx against a frame-waveform model and a line receiver.
module tb_fifo_serial_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int SB  = 1;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  localparam int P = 1;
  localparam int FRAME_LIT = 44;
`else
  localparam int P = 0;
  localparam int FRAME_LIT = 40;
`endif
  localparam int FIFO_DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fifo_serial_tx_if #(.DATA_WIDTH(DW)) bus ();

  fifo_serial_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (SB)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .tx_if  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] sent_q[$];
  logic [7:0] rx_log[$];
  bit         exp_line[$];
  bit         tx_log[$];
  int         pop_cyc[$];
  int         done_cyc[$];

  bit         rx_active = 0;
  int         rx_t = 0;
  logic [7:0] rx_word;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void drive_fifo();
    bus.i_fifo_empty = (fifo_q.size() == 0);
    bus.i_fifo_data  = (fifo_q.size() == 0) ? 8'hEE : fifo_q[0];
  endfunction

  // Whole-frame waveform, one entry per clock cycle.
  function automatic void model_frame(logic [7:0] w);
    bit b[$];
    b.push_back(1'b0);
    for (int i = 0; i < DW; i++) b.push_back(w[i]);
`ifdef FIFO_SERIAL_TX_PARITY_EN
    b.push_back(^w);
`endif
    for (int i = 0; i < SB; i++) b.push_back(1'b1);
    foreach (b[j]) repeat (CPB) exp_line.push_back(b[j]);
  endfunction

  function automatic void rx_sample(bit tx);
    int k;
    if (!rx_active && tx == 1'b0) begin
      rx_active = 1;
      rx_t = 0;
      rx_word = '0;
    end
    if (rx_active) begin
      if (rx_t % CPB == CPB / 2) begin
        k = rx_t / CPB;
        if (k == 0) begin
          check("rx_start", tx, 1'b0);
        end else if (k <= DW) begin
          rx_word[k-1] = tx;
`ifdef FIFO_SERIAL_TX_PARITY_EN
        end else if (k == DW + 1) begin
          check("rx_parity", tx, ^rx_word);
`endif
        end else begin
          check("rx_stop", tx, 1'b1);
          rx_log.push_back(rx_word);
          check("rx_sent_pending", sent_q.size() > 0, 1'b1);
          if (sent_q.size() > 0) check("rx_word", rx_word, sent_q.pop_front());
          rx_active = 0;
        end
      end
      rx_t++;
    end
  endfunction

  // Sample on the falling edge, compare with the model, then advance one cycle.
  task automatic step(input int n);
    bit exp_pop, exp_tx, pop_act;
    repeat (n) begin
      @(negedge clk);
      exp_pop = rst_n && bus.i_en && !bus.i_fifo_empty && (exp_line.size() <= 1);
      exp_tx  = (exp_line.size() > 0) ? exp_line[0] : 1'b1;
      check("tx", bus.o_tx, exp_tx);
      check("pop", bus.o_fifo_pop, exp_pop);
      check("busy", bus.o_busy, exp_line.size() > 0);
      check("frame_done", bus.o_frame_done, exp_line.size() == 1);
      tx_log.push_back(bus.o_tx);
      if (bus.o_fifo_pop) pop_cyc.push_back(cyc);
      if (bus.o_frame_done) done_cyc.push_back(cyc);
      rx_sample(bus.o_tx);
      if (exp_line.size() > 0) void'(exp_line.pop_front());
      if (exp_pop) begin
        model_frame(fifo_q[0]);
        sent_q.push_back(fifo_q[0]);
      end
      pop_act = bus.o_fifo_pop;
      cyc++;
      @(posedge clk);
      #1;
      if (pop_act && fifo_q.size() > 0) void'(fifo_q.pop_front());
      drive_fifo();
    end
  endtask

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    drive_fifo();
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_line.size() > 0 || fifo_q.size() > 0 || rx_active) && n < 3000) begin
      step(1);
      n++;
    end
    check("drain_timeout", n < 3000, 1'b1);
    step(2);
  endtask

  task automatic reset_pulse();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_tx", bus.o_tx, 1'b1);
    check("rst_async_busy", bus.o_busy, 1'b0);
    check("rst_async_pop", bus.o_fifo_pop, 1'b0);
    exp_line.delete();
    sent_q.delete();
    rx_active = 0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int pb, db, rb, pc, r, pushed, n;
    logic [9:0]  a5_bits;
    logic [35:0] wave, want;

    bus.i_en = 1'b1;
    drive_fifo();

    // Reset held, fifo empty
    step(6);
    rst_n = 1'b1;
    step(6);
    check("t1_no_pops", pop_cyc.size(), 0);

    // Single word 0xA5
    pb = pop_cyc.size();
    db = done_cyc.size();
    push(8'hA5);
    step(FRAME_LIT + 10);
    check("t2_pop_count", pop_cyc.size() - pb, 1);
    check("t2_done_count", done_cyc.size() - db, 1);
    pc = pop_cyc[pb];
    check("t2_done_offset", done_cyc[db] - pc, FRAME_LIT);
    a5_bits = 10'b1101001010;
    for (int i = 0; i < 36; i++) begin
      want[i] = a5_bits[i/4];
      wave[i] = tx_log[pc+1+i];
    end
    check("t2_wave", wave, want);
    check("t2_idle_after", tx_log[pc+FRAME_LIT+1], 1'b1);

    // Three preloaded words, back to back
    pb = pop_cyc.size();
    db = done_cyc.size();
    rb = rx_log.size();
    push(8'h01);
    push(8'h80);
    push(8'hFF);
    step(3 * FRAME_LIT + 10);
    check("t3_pop_count", pop_cyc.size() - pb, 3);
    check("t3_gapless_0", pop_cyc[pb+1], done_cyc[db]);
    check("t3_gapless_1", pop_cyc[pb+2], done_cyc[db+1]);
    check("t3_span", done_cyc[db+2] - pop_cyc[pb], 3 * FRAME_LIT);
    check("t3_rx_count", rx_log.size() - rb, 3);
    check("t3_rx0", rx_log[rb], 8'h01);
    check("t3_rx1", rx_log[rb+1], 8'h80);
    check("t3_rx2", rx_log[rb+2], 8'hFF);

    // Enable dropped during data bit 3
    pb = pop_cyc.size();
    db = done_cyc.size();
    push(8'h3C);
    push(8'h55);
    step(18);
    bus.i_en = 1'b0;
    step(FRAME_LIT + 10);
    check("t4_pops_while_disabled", pop_cyc.size() - pb, 1);
    check("t4_frame_len", done_cyc[db] - pop_cyc[pb], FRAME_LIT);
    bus.i_en = 1'b1;
    r = cyc;
    step(2);
    check("t4_pop_on_enable", pop_cyc[pop_cyc.size()-1], r);
    drain();

    // Reset pulse during data bit 5
    rb = rx_log.size();
    push(8'h5A);
    push(8'hC3);
    step(26);
    reset_pulse();
    drain();
    check("t5_rx_count", rx_log.size() - rb, 1);
    check("t5_rx_word", rx_log[rx_log.size()-1], 8'hC3);

    // Frame length with/without parity
    pb = pop_cyc.size();
    db = done_cyc.size();
    push(8'h07);
    drain();
    pc = pop_cyc[pb];
    check("t6_len_07", done_cyc[db] - pc, FRAME_LIT);
`ifdef FIFO_SERIAL_TX_PARITY_EN
    check("t6_parity_07", tx_log[pc+1+CPB*9], 1'b1);
`endif
    pb = pop_cyc.size();
    db = done_cyc.size();
    push(8'h03);
    drain();
    pc = pop_cyc[pb];
    check("t6_len_03", done_cyc[db] - pc, FRAME_LIT);
`ifdef FIFO_SERIAL_TX_PARITY_EN
    check("t6_parity_03", tx_log[pc+1+CPB*9], 1'b0);
`endif

    // Random run: 256 words, random push timing and enable gaps
    rb = rx_log.size();
    pushed = 0;
    n = 0;
    while ((rx_log.size() - rb) < 256 && n < 40000) begin
      if (pushed < 256 && fifo_q.size() < FIFO_DEPTH && $urandom_range(0, 35) == 0) begin
        push(8'($urandom));
        pushed++;
      end
      if ($urandom_range(0, 199) == 0) bus.i_en = ~bus.i_en;
      step(1);
      n++;
    end
    bus.i_en = 1'b1;
    check("rand_timeout", n < 40000, 1'b1);
    check("rand_rx_count", rx_log.size() - rb, 256);
    drain();
    check("rand_fifo_empty", fifo_q.size(), 0);
    check("rand_sent_left", sent_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
